// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse receiver (and its transmitter counterpart):
//   - receiver FSM state encoding
//   - invalid-letter marker and maximum symbols per letter
//   - the 26 (length, pattern) codes for A..Z.
//     Pattern bit i holds symbol i (first symbol in bit 0), 1 = dash.
// No ports (package).
// -----------------------------------------------------------------------------
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam logic [4:0] LETTER_INVALID = 5'd31;
  localparam int         MAX_SYM        = 4;
  localparam int         NUM_LETTERS    = 26;

  // Each entry is {len[2:0], pat[3:0]}, indexed by letter (0 = A).
  localparam logic [6:0] CODE_TABLE [NUM_LETTERS] = '{
    {3'd2, 4'b0010},  // A .-
    {3'd4, 4'b0001},  // B -...
    {3'd4, 4'b0101},  // C -.-.
    {3'd3, 4'b0001},  // D -..
    {3'd1, 4'b0000},  // E .
    {3'd4, 4'b0100},  // F ..-.
    {3'd3, 4'b0011},  // G --.
    {3'd4, 4'b0000},  // H ....
    {3'd2, 4'b0000},  // I ..
    {3'd4, 4'b1110},  // J .---
    {3'd3, 4'b0101},  // K -.-
    {3'd4, 4'b0010},  // L .-..
    {3'd2, 4'b0011},  // M --
    {3'd2, 4'b0001},  // N -.
    {3'd3, 4'b0111},  // O ---
    {3'd4, 4'b0110},  // P .--.
    {3'd4, 4'b1011},  // Q --.-
    {3'd3, 4'b0010},  // R .-.
    {3'd3, 4'b0000},  // S ...
    {3'd1, 4'b0001},  // T -
    {3'd3, 4'b0100},  // U ..-
    {3'd4, 4'b1000},  // V ...-
    {3'd3, 4'b0110},  // W .--
    {3'd4, 4'b1001},  // X -..-
    {3'd4, 4'b1101},  // Y -.--
    {3'd4, 4'b0011}   // Z --..
  };

endpackage

// File: rtl/morse_receiver_if.sv
// -----------------------------------------------------------------------------
// morse_receiver_if
// Groups the receiver's timing/key inputs and decoded-letter outputs.
//   tick         unit-time strobe, one clk wide
//   key_in       raw key line (1 = tone), asynchronous to clk
//   letter       decoded index 0..25, 31 when invalid
//   letter_valid one-clk pulse when the letter outputs update
//   letter_err   overflow or unmapped code, held with letter
//   sym_len      symbols in the emitted letter
//   sym_pat      symbol pattern, bit0 = first symbol, 1 = dash
//   busy         receiver not idle
// Modports: master = the receiver, slave = key source / display side.
// -----------------------------------------------------------------------------
interface morse_receiver_if;
  logic       tick;
  logic       key_in;
  logic [4:0] letter;
  logic       letter_valid;
  logic       letter_err;
  logic [2:0] sym_len;
  logic [3:0] sym_pat;
  logic       busy;

  modport master (
    input  tick, key_in,
    output letter, letter_valid, letter_err, sym_len, sym_pat, busy
  );

  modport slave (
    output tick, key_in,
    input  letter, letter_valid, letter_err, sym_len, sym_pat, busy
  );
endinterface

// File: rtl/morse_lut.sv
// -----------------------------------------------------------------------------
// morse_lut
// Combinational code-to-letter lookup. Exact match on both length and pattern.
//   len  in  3  number of symbols
//   pat  in  4  symbol pattern (bit0 first, 1 = dash)
//   idx  out 5  letter index 0..25, LETTER_INVALID when no match
//   hit  out 1  1 when a table entry matched
// -----------------------------------------------------------------------------
module morse_lut
  import morse_pkg::*;
(
  input  logic [2:0] len,
  input  logic [3:0] pat,
  output logic [4:0] idx,
  output logic       hit
);

  // Table codes are unique, so at most one entry can match.
  always_comb begin
    idx = LETTER_INVALID;
    hit = 1'b0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (CODE_TABLE[i] == {len, pat}) begin
        idx = 5'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_receiver.sv
// -----------------------------------------------------------------------------
// morse_receiver
// Samples a keyed on/off line on unit ticks, classifies marks as dots/dashes,
// and decodes each letter (ended by a GAP_LETTER-tick space) into 0..25.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    morse_receiver_if.master (tick/key_in in, letter outputs out)
// Parameters: DASH_MIN (dash threshold in ticks), GAP_LETTER (space ticks
// ending a letter), CNT_W (mark/space counter width, saturating).
// -----------------------------------------------------------------------------
module morse_receiver
  import morse_pkg::*;
#(
  parameter int DASH_MIN   = 2,
  parameter int GAP_LETTER = 3,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  morse_receiver_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DASH_TH = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] GAP_TH  = CNT_W'(GAP_LETTER);
  localparam logic [2:0]       SYM_MAX = 3'(MAX_SYM);

  logic             r_key_s1;
  logic             r_key_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_mark_cnt;
  logic [CNT_W-1:0] r_space_cnt;
  logic [2:0]       r_sym_cnt;
  logic [3:0]       r_buf;
  logic             r_ovf;

  logic [4:0]       r_letter;
  logic             r_letter_valid;
  logic             r_letter_err;
  logic [2:0]       r_sym_len;
  logic [3:0]       r_sym_pat;

  logic [CNT_W-1:0] w_mark_inc;
  logic [CNT_W-1:0] w_space_inc;
  logic             w_dash;
  logic [4:0]       w_lut_idx;
  logic             w_lut_hit;
  logic             w_invalid;

  // Two-flop synchroniser: key_in is asynchronous to clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_s1 <= 1'b0;
      r_key_s2 <= 1'b0;
    end else begin
      r_key_s1 <= bus.key_in;
      r_key_s2 <= r_key_s1;
    end
  end

  assign w_mark_inc  = (r_mark_cnt  == CNT_MAX) ? CNT_MAX : r_mark_cnt  + CNT_ONE;
  assign w_space_inc = (r_space_cnt == CNT_MAX) ? CNT_MAX : r_space_cnt + CNT_ONE;
  // A saturated mark stays >= DASH_TH, so very long marks remain dashes.
  assign w_dash      = (r_mark_cnt >= DASH_TH);

  morse_lut u_lut (
    .len (r_sym_cnt),
    .pat (r_buf),
    .idx (w_lut_idx),
    .hit (w_lut_hit)
  );

  assign w_invalid = r_ovf | ~w_lut_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_mark_cnt     <= '0;
      r_space_cnt    <= '0;
      r_sym_cnt      <= '0;
      r_buf          <= '0;
      r_ovf          <= 1'b0;
      r_letter       <= '0;
      r_letter_valid <= 1'b0;
      r_letter_err   <= 1'b0;
      r_sym_len      <= '0;
      r_sym_pat      <= '0;
    end else begin
      r_letter_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.tick && r_key_s2) begin
            r_state    <= MARK;
            r_mark_cnt <= CNT_ONE;
          end
        end
        MARK: begin
          if (bus.tick) begin
            if (r_key_s2) begin
              r_mark_cnt <= w_mark_inc;
            end else begin
              // Symbols beyond the fourth only flag overflow; buffer is kept.
              if (r_sym_cnt < SYM_MAX) begin
                r_buf[r_sym_cnt[1:0]] <= w_dash;
                r_sym_cnt             <= r_sym_cnt + 3'd1;
              end else begin
                r_ovf <= 1'b1;
              end
              r_state     <= SPACE;
              r_space_cnt <= CNT_ONE;
            end
          end
        end
        SPACE: begin
          if (bus.tick) begin
            if (r_key_s2) begin
              r_state    <= MARK;
              r_mark_cnt <= CNT_ONE;
            end else begin
              r_space_cnt <= w_space_inc;
              // Outputs load on the edge entering EMIT so letter_valid is
              // high exactly during the EMIT cycle.
              if (w_space_inc >= GAP_TH) begin
                r_state        <= EMIT;
                r_letter_valid <= 1'b1;
                r_sym_len      <= r_sym_cnt;
                r_sym_pat      <= r_buf;
                r_letter       <= w_invalid ? LETTER_INVALID : w_lut_idx;
                r_letter_err   <= w_invalid;
              end
            end
          end
        end
        EMIT: begin
          // Single cycle; any tick here is deliberately ignored.
          r_state     <= IDLE;
          r_mark_cnt  <= '0;
          r_space_cnt <= '0;
          r_sym_cnt   <= '0;
          r_buf       <= '0;
          r_ovf       <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.letter       = r_letter;
  assign bus.letter_valid = r_letter_valid;
  assign bus.letter_err   = r_letter_err;
  assign bus.sym_len      = r_sym_len;
  assign bus.sym_pat      = r_sym_pat;
  assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_morse_receiver.sv
// -----------------------------------------------------------------------------
// tb_morse_receiver
// Directed bench for morse_receiver (DASH_MIN=2, GAP_LETTER=3, tick every 4
// clks). Expected letters are queued as stimulus is driven and compared when
// letter_valid pulses.
// -----------------------------------------------------------------------------
module tb_morse_receiver;

  logic clk;
  logic reset;

  morse_receiver_if bus ();

  morse_receiver #(
    .DASH_MIN   (2),
    .GAP_LETTER (3),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] letter;
    logic       err;
    logic [2:0] len;
    logic [3:0] pat;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   n_valid = 0;
  int   n_exp   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every letter_valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.letter_valid === 1'b1) begin
      n_valid++;
      chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("letter",     32'(bus.letter),     32'(e.letter));
        chk("letter_err", 32'(bus.letter_err), 32'(e.err));
        chk("sym_len",    32'(bus.sym_len),    32'(e.len));
        chk("sym_pat",    32'(bus.sym_pat),    32'(e.pat));
      end
    end
  end

  task automatic push(input logic [4:0] l, input logic er, input logic [2:0] ln, input logic [3:0] p);
    exp_t e;
    e.letter = l; e.err = er; e.len = ln; e.pat = p;
    sb.push_back(e);
    n_exp++;
  endtask

  // One unit: key level settles through the synchroniser, then a tick.
  task automatic unit(input logic k);
    bus.key_in = k;
    repeat (3) @(posedge clk);
    #1 bus.tick = 1'b1;
    @(posedge clk);
    #1 bus.tick = 1'b0;
  endtask

  task automatic key(input logic k, input int n);
    for (int i = 0; i < n; i++) unit(k);
  endtask

  // Final n space ticks of a letter; valid must be high 1 clk after the last.
  task automatic close_letter(input string tag, input int n);
    key(1'b0, n);
    chk(tag, 32'(bus.letter_valid), 32'd1);
  endtask

  initial begin
    reset      = 1'b0;
    bus.tick   = 1'b0;
    bus.key_in = 1'b0;
    #23;
    chk("rst_letter", 32'(bus.letter),       32'd0);
    chk("rst_valid",  32'(bus.letter_valid), 32'd0);
    chk("rst_err",    32'(bus.letter_err),   32'd0);
    chk("rst_len",    32'(bus.sym_len),      32'd0);
    chk("rst_pat",    32'(bus.sym_pat),      32'd0);
    chk("rst_busy",   32'(bus.busy),         32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // E: dot
    push(5'd4, 1'b0, 3'd1, 4'b0000);
    key(1'b1, 1);
    chk("busy_mark", 32'(bus.busy), 32'd1);
    close_letter("lat_E", 3);

    // A: dot dash, no emit after the 1-tick gap
    push(5'd0, 1'b0, 3'd2, 4'b0010);
    key(1'b1, 1); key(1'b0, 1);
    chk("A_gap_novalid", 32'(bus.letter_valid), 32'd0);
    chk("A_gap_busy",    32'(bus.busy),         32'd1);
    key(1'b1, 3);
    close_letter("lat_A", 3);

    // Q then T back to back; T mark exceeds counter saturation
    push(5'd16, 1'b0, 3'd4, 4'b1011);
    key(1'b1, 2); key(1'b0, 1);
    key(1'b1, 2); key(1'b0, 1);
    key(1'b1, 1); key(1'b0, 1);
    key(1'b1, 3);
    close_letter("lat_Q", 3);
    push(5'd19, 1'b0, 3'd1, 4'b0001);
    key(1'b1, 17);
    chk("long_mark_busy", 32'(bus.busy), 32'd1);
    close_letter("lat_T", 3);

    // Overflow: five dots
    push(5'd31, 1'b1, 3'd4, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      key(1'b1, 1); key(1'b0, 1);
    end
    key(1'b1, 1);
    close_letter("lat_ovf", 3);

    // Unmapped: dot dot dash dash
    push(5'd31, 1'b1, 3'd4, 4'b1100);
    key(1'b1, 1); key(1'b0, 1);
    key(1'b1, 1); key(1'b0, 1);
    key(1'b1, 2); key(1'b0, 1);
    key(1'b1, 2);
    close_letter("lat_unm", 3);

    // Reset during the second mark of A: partial letter discarded
    key(1'b1, 1); key(1'b0, 1); key(1'b1, 1);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_letter", 32'(bus.letter),       32'd0);
    chk("mid_rst_err",    32'(bus.letter_err),   32'd0);
    chk("mid_rst_len",    32'(bus.sym_len),      32'd0);
    chk("mid_rst_pat",    32'(bus.sym_pat),      32'd0);
    chk("mid_rst_busy",   32'(bus.busy),         32'd0);
    chk("mid_rst_valid",  32'(bus.letter_valid), 32'd0);
    bus.key_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    push(5'd4, 1'b0, 3'd1, 4'b0000);
    key(1'b1, 1);
    close_letter("lat_E_after_rst", 3);

    // Tick held low 100 clks mid-SPACE while the key is on: nothing changes
    push(5'd4, 1'b0, 3'd1, 4'b0000);
    key(1'b1, 1); key(1'b0, 1);
    bus.key_in = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("hold_busy",    32'(bus.busy),         32'd1);
    chk("hold_novalid", 32'(bus.letter_valid), 32'd0);
    close_letter("lat_hold", 2);

    repeat (10) @(posedge clk);
    #1;
    chk("sb_drained",  32'(sb.size()), 32'd0);
    chk("valid_count", 32'(n_valid),   32'(n_exp));
    chk("idle_end",    32'(bus.busy),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_receiver.md
Name: morse_receiver

Overview:
- Receive-side counterpart of the Morse transmitter: samples a keyed on/off line, times marks and spaces in unit ticks, classifies dots and dashes, and decodes each completed letter into a 0–25 index (A–Z).
- Sits between a board key/switch (or looped-back transmitter output) and the letter display/LED logic.
- One clock domain. Timing advances only on a one-cycle `tick` strobe from a shared divider.

Parameters:
- DASH_MIN, 2: mark length in ticks at or above which a mark is a dash; shorter marks are dots.
- GAP_LETTER, 3: consecutive space ticks that end a letter.
- CNT_W, 4: width of the mark/space counters; counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- tick  in  1  unit-time enable, one clk wide.
- key_in  in  1  raw key line, 1 = tone on; asynchronous to clk.
- letter  out  5  decoded letter index, 0=A … 25=Z; 31 when invalid.
- letter_valid  out  1  one-clk pulse when letter/sym_len/sym_pat/letter_err update.
- letter_err  out  1  1 = overflow (>4 symbols) or unmapped code; held with letter.
- sym_len  out  3  number of symbols in the emitted letter, 1–4.
- sym_pat  out  4  symbol pattern; bit i = symbol i (first symbol in bit 0), 1 = dash; unused bits 0.
- busy  out  1  1 when not in IDLE.

Behaviour:
- Reset (async, reset=0): state=IDLE; counters, symbol buffer and overflow flag cleared. Outputs: letter=0, letter_valid=0, letter_err=0, sym_len=0, sym_pat=0, busy=0.
- Input synchronisation: key_in passes through a 2-flop synchroniser (key_s) before any use.
- Sampling: key_s is examined only in cycles where tick=1; with tick=0, state and counters hold.
- FSM states: IDLE, MARK, SPACE, EMIT.
- IDLE, tick & key_s=1: go to MARK, mark_cnt=1. Otherwise stay.
- MARK, tick & key_s=1: mark_cnt += 1, saturating.
- MARK, tick & key_s=0: classify the mark as dash if mark_cnt>=DASH_MIN, else dot.
  - If sym_cnt<4: buf[sym_cnt]=dash, sym_cnt+=1.
  - Else: set ovf and leave the buffer unchanged.
  - Then go to SPACE, space_cnt=1.
- SPACE, tick & key_s=1: go to MARK, mark_cnt=1. The inter-symbol gap is accepted at any length below GAP_LETTER.
- SPACE, tick & key_s=0: space_cnt += 1. If the new value >= GAP_LETTER, go to EMIT.
- EMIT: lasts exactly one clk regardless of tick, then go to IDLE. Buffer, sym_cnt, ovf and counters clear on exit.
- Output registers load on the clk edge entering EMIT, so letter_valid is high during the EMIT cycle. Latency is 1 clk after the tick that completes the gap.
- Values loaded at EMIT:
  - sym_len = sym_cnt, sym_pat = buf.
  - letter = LUT result, or 31 if invalid.
  - letter_err = ovf | ~lut_hit.
- letter, letter_err, sym_len and sym_pat hold until the next EMIT.
- letter_valid is 0 in every other cycle.
- A tick during EMIT is ignored. A mark starting on that tick is detected on the next tick from IDLE.
- Mark longer than the saturation limit: still a dash, no error.
- Key held on indefinitely: stays in MARK, no emit.
- Reset asserted mid-letter: the partial letter is discarded and no letter_valid is produced; outputs return to reset values.

Decomposition:
- morse_pkg holds:
  - state enum (IDLE, MARK, SPACE, EMIT)
  - LETTER_INVALID = 5'd31
  - MAX_SYM = 4
  - the 26 (len, pattern) code constants shared with the transmitter
- Sub-module morse_lut: purely combinational, inputs (len[2:0], pat[3:0]), outputs (idx[4:0], hit). Exact match on both len and pat.

Test Plan (DASH_MIN=2, GAP_LETTER=3, tick every 4 clks):
- "E": key on 1 tick, off 3 ticks -> one letter_valid pulse, 1 clk after the 3rd off tick; letter=4, sym_len=1, sym_pat=0000, err=0.
- "A": on 1, off 1, on 3, off 3 ticks -> letter=0, sym_len=2, sym_pat=0010, err=0. Check no emit after the 1-tick inter-symbol gap.
- "Q" then "T" back-to-back: dash-dash-dot-dash (sym_pat=1011, len 4), 3-tick gap, then one dash -> letters 16 then 19, exactly two valid pulses.
- Overflow: five dots, then 3-tick gap -> letter_err=1, sym_len=4, sym_pat=0000, letter=31.
- Unmapped code dot-dot-dash-dash (len 4, pat 1100) -> letter=31, letter_err=1.
- Reset pulse low during the 2nd mark of "A" -> outputs zero immediately (async). Subsequent "E" decodes correctly with no stale symbols. Also: tick held 0 for 100 clks mid-SPACE -> no state change.
